// File: rtl/ysyx_axi4_mem_slave_if.sv
// AXI4 bus bundle between the core's master port and a memory responder.
// Ports: five AXI4 channels (AR, R, AW, W, B); master/slave modports.
interface ysyx_axi4_mem_slave_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] s_araddr;
   logic            s_arvalid;
   logic [3:0]      s_arid;
   logic [7:0]      s_arlen;
   logic [2:0]      s_arsize;
   logic [1:0]      s_arburst;
   logic            s_arready;
   logic [XLEN-1:0] s_rdata;
   logic [1:0]      s_rresp;
   logic [3:0]      s_rid;
   logic            s_rlast;
   logic            s_rvalid;
   logic            s_rready;
   logic [XLEN-1:0] s_awaddr;
   logic            s_awvalid;
   logic [3:0]      s_awid;
   logic [7:0]      s_awlen;
   logic [2:0]      s_awsize;
   logic [1:0]      s_awburst;
   logic            s_awready;
   logic [XLEN-1:0] s_wdata;
   logic [3:0]      s_wstrb;
   logic            s_wlast;
   logic            s_wvalid;
   logic            s_wready;
   logic [3:0]      s_bid;
   logic [1:0]      s_bresp;
   logic            s_bvalid;
   logic            s_bready;

   modport master (
      output s_araddr, s_arvalid, s_arid, s_arlen, s_arsize, s_arburst,
      input  s_arready,
      input  s_rdata, s_rresp, s_rid, s_rlast, s_rvalid,
      output s_rready,
      output s_awaddr, s_awvalid, s_awid, s_awlen, s_awsize, s_awburst,
      input  s_awready,
      output s_wdata, s_wstrb, s_wlast, s_wvalid,
      input  s_wready,
      input  s_bid, s_bresp, s_bvalid,
      output s_bready
   );

   modport slave (
      input  s_araddr, s_arvalid, s_arid, s_arlen, s_arsize, s_arburst,
      output s_arready,
      output s_rdata, s_rresp, s_rid, s_rlast, s_rvalid,
      input  s_rready,
      input  s_awaddr, s_awvalid, s_awid, s_awlen, s_awsize, s_awburst,
      output s_awready,
      input  s_wdata, s_wstrb, s_wlast, s_wvalid,
      output s_wready,
      output s_bid, s_bresp, s_bvalid,
      input  s_bready
   );
endinterface

// File: rtl/ysyx_axi4_mem_slave.sv
// AXI4 memory responder: word memory, INCR/FIXED bursts, independent R/W.
// Ports: clock, reset (sync, active-high), s (AXI4 slave modport).
// Optional YSYX_AXI_SLAVE_DELAY_EN: LFSR-driven response delay and ready gating.
module ysyx_axi4_mem_slave #(
   parameter int          XLEN       = 32,
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h80000000
) (
   input logic clock,
   input logic reset,
   ysyx_axi4_mem_slave_if.slave s
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH) << 2;
   localparam logic [1:0] FIXED  = 2'b00;
   localparam logic [1:0] WRAP   = 2'b10;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;
   typedef enum logic [1:0] {W_ADDR, W_DATA, W_WAIT, W_RESP} wstate_e;

   logic [XLEN-1:0] mem_q [DEPTH];

   // Unsigned offset compare also rejects addresses below the base.
   function automatic logic in_rng(input logic [XLEN-1:0] a);
      return (a - BASE_ADDR) < SPAN;
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] widx(input logic [XLEN-1:0] a);
      return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
   endfunction

   function automatic logic [XLEN-1:0] nxt(input logic [XLEN-1:0] a,
                                          input logic [1:0] b);
      return (b == FIXED) ? a : a + XLEN'(4);
   endfunction

   logic [1:0] dly;
   logic       gate;
`ifdef YSYX_AXI_SLAVE_DELAY_EN
   logic [7:0] lfsr_q;
   always_ff @(posedge clock) begin
      if (reset) lfsr_q <= 8'hA5;
      else lfsr_q <= {lfsr_q[6:0],
                      lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end
   assign dly  = lfsr_q[1:0];
   assign gate = lfsr_q[2];
`else
   assign dly  = 2'd0;
   assign gate = 1'b0;
`endif

   // Holds readies low until the first cycle out of reset.
   logic rdy_q;

   rstate_e         rs_q, rs_d;
   logic [XLEN-1:0] raddr_q, raddr_d, rdata_q, rdata_d;
   logic [7:0]      rlen_q, rlen_d, rbeat_q, rbeat_d;
   logic [3:0]      rid_q, rid_d;
   logic [1:0]      rburst_q, rburst_d, rresp_q, rresp_d;
   logic [1:0]      rcnt_q, rcnt_d;
   logic            rbad_q, rbad_d;
   logic            ld;
   logic [XLEN-1:0] ld_addr;

   wstate_e         ws_q, ws_d;
   logic [XLEN-1:0] waddr_q, waddr_d;
   logic [7:0]      wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic [3:0]      wid_q, wid_d;
   logic [1:0]      wburst_q, wburst_d, bresp_q, bresp_d;
   logic [1:0]      wcnt_q, wcnt_d;
   logic            wdec_q, wdec_d, wslv_q, wslv_d;
   logic            mem_we, w_inr, w_cnt_last;

   assign s.s_rdata  = rdata_q;
   assign s.s_rresp  = rresp_q;
   assign s.s_rid    = rid_q;
   assign s.s_rlast  = (rs_q == R_DATA) && (rbeat_q == rlen_q);
   assign s.s_bid    = wid_q;
   assign s.s_bresp  = bresp_q;

   assign w_inr      = in_rng(waddr_q);
   assign w_cnt_last = (wbeat_q == wlen_q);

   always_comb begin
      rs_d = rs_q; raddr_d = raddr_q; rlen_d = rlen_q; rbeat_d = rbeat_q;
      rid_d = rid_q; rburst_d = rburst_q; rbad_d = rbad_q; rcnt_d = rcnt_q;
      rdata_d = rdata_q; rresp_d = rresp_q;
      ld = 1'b0; ld_addr = raddr_q;
      s.s_arready = 1'b0;
      s.s_rvalid  = 1'b0;
      unique case (rs_q)
         R_IDLE: begin
            s.s_arready = rdy_q & ~gate;
            if (s.s_arvalid & s.s_arready) begin
               raddr_d  = s.s_araddr;
               rlen_d   = s.s_arlen;
               rid_d    = s.s_arid;
               rburst_d = s.s_arburst;
               rbad_d   = (s.s_arsize > 3'd2) || (s.s_arburst == WRAP);
               rbeat_d  = 8'd0;
               ld       = 1'b1;
               ld_addr  = s.s_araddr;
               rcnt_d   = dly;
               rs_d     = (dly == 2'd0) ? R_DATA : R_WAIT;
            end
         end
         R_WAIT: begin
            rcnt_d = rcnt_q - 2'd1;
            if (rcnt_q == 2'd1) rs_d = R_DATA;
         end
         R_DATA: begin
            s.s_rvalid = 1'b1;
            if (s.s_rready) begin
               if (s.s_rlast) begin
                  rs_d = R_IDLE;
               end else begin
                  raddr_d = nxt(raddr_q, rburst_q);
                  rbeat_d = rbeat_q + 8'd1;
                  ld      = 1'b1;
                  ld_addr = raddr_d;
               end
            end
         end
         default: rs_d = R_IDLE;
      endcase
      // Read data is registered, so a same-cycle write is not visible.
      if (ld) begin
         if (rbad_d) begin
            rdata_d = '0; rresp_d = SLVERR;
         end else if (!in_rng(ld_addr)) begin
            rdata_d = '0; rresp_d = DECERR;
         end else begin
            rdata_d = mem_q[widx(ld_addr)]; rresp_d = OKAY;
         end
      end
   end

   always_comb begin
      ws_d = ws_q; waddr_d = waddr_q; wlen_d = wlen_q; wbeat_d = wbeat_q;
      wid_d = wid_q; wburst_d = wburst_q; wdec_d = wdec_q; wslv_d = wslv_q;
      wcnt_d = wcnt_q; bresp_d = bresp_q;
      mem_we = 1'b0;
      s.s_awready = 1'b0;
      s.s_wready  = 1'b0;
      s.s_bvalid  = 1'b0;
      unique case (ws_q)
         W_ADDR: begin
            s.s_awready = rdy_q & ~gate;
            if (s.s_awvalid & s.s_awready) begin
               waddr_d  = s.s_awaddr;
               wlen_d   = s.s_awlen;
               wid_d    = s.s_awid;
               wburst_d = s.s_awburst;
               wbeat_d  = 8'd0;
               wdec_d   = 1'b0;
               wslv_d   = s.s_awsize > 3'd2;
               ws_d     = W_DATA;
            end
         end
         W_DATA: begin
            s.s_wready = 1'b1;
            if (s.s_wvalid) begin
               mem_we = w_inr & ~reset;
               wdec_d = wdec_q | ~w_inr;
               // wlast must coincide exactly with the final counted beat.
               wslv_d = wslv_q | (w_cnt_last ^ s.s_wlast);
               if (w_cnt_last | s.s_wlast) begin
                  bresp_d = wdec_d ? DECERR : (wslv_d ? SLVERR : OKAY);
                  wcnt_d  = dly;
                  ws_d    = (dly == 2'd0) ? W_RESP : W_WAIT;
               end else begin
                  wbeat_d = wbeat_q + 8'd1;
                  waddr_d = nxt(waddr_q, wburst_q);
               end
            end
         end
         W_WAIT: begin
            wcnt_d = wcnt_q - 2'd1;
            if (wcnt_q == 2'd1) ws_d = W_RESP;
         end
         W_RESP: begin
            s.s_bvalid = 1'b1;
            if (s.s_bready) ws_d = W_ADDR;
         end
         default: ws_d = W_ADDR;
      endcase
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int i = 0; i < XLEN / 8; i++)
            if (s.s_wstrb[i])
               mem_q[widx(waddr_q)][8*i +: 8] <= s.s_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rdy_q <= 1'b0;
         rs_q <= R_IDLE; raddr_q <= '0; rlen_q <= '0; rbeat_q <= '0;
         rid_q <= '0; rburst_q <= '0; rbad_q <= 1'b0; rcnt_q <= '0;
         rdata_q <= '0; rresp_q <= '0;
         ws_q <= W_ADDR; waddr_q <= '0; wlen_q <= '0; wbeat_q <= '0;
         wid_q <= '0; wburst_q <= '0; wdec_q <= 1'b0; wslv_q <= 1'b0;
         wcnt_q <= '0; bresp_q <= '0;
      end else begin
         rdy_q <= 1'b1;
         rs_q <= rs_d; raddr_q <= raddr_d; rlen_q <= rlen_d; rbeat_q <= rbeat_d;
         rid_q <= rid_d; rburst_q <= rburst_d; rbad_q <= rbad_d; rcnt_q <= rcnt_d;
         rdata_q <= rdata_d; rresp_q <= rresp_d;
         ws_q <= ws_d; waddr_q <= waddr_d; wlen_q <= wlen_d; wbeat_q <= wbeat_d;
         wid_q <= wid_d; wburst_q <= wburst_d; wdec_q <= wdec_d; wslv_q <= wslv_d;
         wcnt_q <= wcnt_d; bresp_q <= bresp_d;
      end
   end
endmodule
